// File: rtl/level_sequencer.sv
// level_sequencer: drives the level loader's start/ready/done handshake.
// It owns the committed level index, picks the next load target
// (boot, next, restart or jump), holds the game while the board is rewritten,
// and flags a loader that never finishes.
module level_sequencer #(
    parameter int NUM_LEVELS = 2,
    parameter int LVL_W      = 1,
    parameter int TIMEOUT    = 127
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next_req,
    input  logic             restart_req,
    input  logic             jump_req,
    input  logic [LVL_W-1:0] jump_level,
    input  logic             loader_ready,
    input  logic             loader_done,
    output logic             loader_start,
    output logic [LVL_W-1:0] level_sel,
    output logic [LVL_W-1:0] cur_level,
    output logic             game_hold,
    output logic             level_valid,
    output logic             err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [LVL_W:0]   NUM_LVL  = (LVL_W + 1)'(NUM_LEVELS);
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_REL,
        S_ERR
    } state_t;

    // Encoded so that a numerically larger value is a higher priority.
    typedef enum logic [1:0] {
        REQ_NONE    = 2'd0,
        REQ_NEXT    = 2'd1,
        REQ_RESTART = 2'd2,
        REQ_JUMP    = 2'd3
    } req_t;

    state_t             state_q, state_d;
    req_t               pend_kind_q, pend_kind_d;
    logic [LVL_W-1:0]   pend_jump_q, pend_jump_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LVL_W-1:0]   sel_d, cur_d;
    logic               err_d, start_d;

    logic               jump_ok;
    logic               busy;
    req_t               in_kind;
    req_t               svc_kind;
    logic [LVL_W-1:0]   svc_jump;
    logic [LVL_W-1:0]   next_level;
    logic [LVL_W-1:0]   svc_target;

    // An out-of-range jump is treated as if it was never requested.
    assign jump_ok = ({1'b0, jump_level} < NUM_LVL);

    // Requests arriving while a load is in flight are parked in the pending slot.
    assign busy = (state_q == S_BOOT) || (state_q == S_WAIT) ||
                  (state_q == S_LOAD) || (state_q == S_REL);

    assign game_hold   = (state_q != S_IDLE);
    assign level_valid = (state_q == S_IDLE);

    // Reduce this cycle's request pulses to the single highest-priority valid one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        in_kind = REQ_NONE;
        if (jump_req && jump_ok) begin
            in_kind = REQ_JUMP;
        end else if (restart_req) begin
            in_kind = REQ_RESTART;
        end else if (next_req) begin
            in_kind = REQ_NEXT;
        end
    end

    // Pick what S_IDLE serves (pending wins ties) and resolve it to a level index.
    always_comb begin
        svc_kind = pend_kind_q;
        svc_jump = pend_jump_q;
        if (in_kind > pend_kind_q) begin
            svc_kind = in_kind;
            svc_jump = jump_level;
        end
        next_level = (cur_level == LAST_LVL) ? '0 : cur_level + 1'b1;
        case (svc_kind)
            REQ_JUMP:    svc_target = svc_jump;
            REQ_RESTART: svc_target = cur_level;
            REQ_NEXT:    svc_target = next_level;
            default:     svc_target = level_sel;
        endcase
    end

    // Next-state and next-register values for the load sequencing FSM.
    always_comb begin
        state_d     = state_q;
        sel_d       = level_sel;
        cur_d       = cur_level;
        err_d       = err;
        pend_kind_d = pend_kind_q;
        pend_jump_d = pend_jump_q;

        if (busy && (in_kind > pend_kind_q)) begin
            pend_kind_d = in_kind;
            pend_jump_d = jump_level;
        end

        case (state_q)
            S_BOOT: begin
                sel_d   = '0;
                state_d = loader_ready ? S_LOAD : S_WAIT;
            end
            S_IDLE: begin
                if (svc_kind != REQ_NONE) begin
                    sel_d       = svc_target;
                    pend_kind_d = REQ_NONE;
                    state_d     = loader_ready ? S_LOAD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (loader_ready) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (loader_done) begin
                    cur_d   = level_sel;
                    state_d = S_REL;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_REL: begin
                if (!loader_done && loader_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                // Only a restart is honoured here; it retries the same level_sel.
                if (restart_req) begin
                    err_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_BOOT;
        endcase

        // loader_start is high exactly while in S_LOAD, so level_sel cannot move under it.
        start_d = (state_d == S_LOAD);
        // Counter restarts from zero on every entry to S_LOAD.
        cnt_d   = (state_q == S_LOAD) ? cnt_q + 1'b1 : '0;
    end

    // State and output registers; reset also drops loader_start without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_BOOT;
            loader_start <= 1'b0;
            level_sel    <= '0;
            cur_level    <= '0;
            err          <= 1'b0;
            pend_kind_q  <= REQ_NONE;
            pend_jump_q  <= '0;
            cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            loader_start <= start_d;
            level_sel    <= sel_d;
            cur_level    <= cur_d;
            err          <= err_d;
            pend_kind_q  <= pend_kind_d;
            pend_jump_q  <= pend_jump_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Controller that sequences the level loader (start/ready/done handshake) on behalf of the game logic.
- Owns the current-level register and chooses which level the loader fetches: boot load, next, restart or jump.
- Freezes game logic while the board is being rewritten.
- Watches for a hung loader and flags it.

Parameters:
- NUM_LEVELS, 2: number of levels stored in level memory; legal indices are 0..NUM_LEVELS-1.
- LVL_W, 1: width of level index; must satisfy 2^LVL_W >= NUM_LEVELS.
- TIMEOUT, 127: maximum cycles in S_LOAD waiting for loader_done before error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- next_req  in  1  one-cycle pulse: advance to next level.
- restart_req  in  1  one-cycle pulse: reload current level; also retries from error.
- jump_req  in  1  one-cycle pulse: load level jump_level.
- jump_level  in  LVL_W  target index for jump_req.
- loader_ready  in  1  loader idle.
- loader_done  in  1  loader finished; held while loader_start held.
- loader_start  out  LVL_W-independent 1  start to loader, registered.
- level_sel  out  LVL_W  level index driven to loader, registered, stable for the whole load.
- cur_level  out  LVL_W  last successfully loaded level, registered.
- game_hold  out  1  high whenever state != S_IDLE.
- level_valid  out  1  high only in S_IDLE; board registers hold a complete level.
- err  out  1  sticky loader-timeout flag, registered.

Behaviour:
- Reset (reset=0, asynchronous) forces these values:
  - state S_BOOT; loader_start 0; level_sel 0; cur_level 0; err 0.
  - game_hold 1; level_valid 0; pending slot empty; timeout counter 0.
- States and transitions:
  - S_BOOT: load target 0 unconditionally. Next state is S_LOAD if loader_ready, else S_WAIT.
  - S_IDLE: if a request or pending slot is present, resolve the target and latch it into level_sel. Next state is S_LOAD if loader_ready, else S_WAIT. loader_start rises on the same edge that enters S_LOAD.
  - S_WAIT: loader_start=0. Move to S_LOAD on the first cycle loader_ready=1.
  - S_LOAD:
    - loader_start=1; the timeout counter increments every cycle.
    - On loader_done=1: cur_level<=level_sel, loader_start<=0, go to S_REL.
    - If the counter reaches TIMEOUT with no done: loader_start<=0, err<=1, go to S_ERR.
  - S_REL: loader_start=0. Return to S_IDLE when loader_done=0 and loader_ready=1.
  - S_ERR:
    - game_hold=1, level_valid=0.
    - restart_req clears err and retries the same level_sel via S_WAIT.
    - next_req and jump_req are ignored and are not latched.
- Request resolution, one target per load:
  - Priority is jump > restart > next.
  - next: (cur_level+1) wraps to 0 at NUM_LEVELS-1.
  - restart: cur_level.
  - jump: jump_level. If jump_level >= NUM_LEVELS the jump is dropped and the lower-priority request, if any, is used instead.
- Requests arriving in S_BOOT, S_WAIT, S_LOAD or S_REL go to a single pending slot:
  - A higher-priority request overwrites a lower one; equal or lower priority is discarded.
  - The pending next is evaluated against cur_level at service time, i.e. after commit.
- The pending slot is serviced on the first S_IDLE cycle. level_valid pulses high for exactly that one cycle, then the new load begins.
- A request arriving in the same cycle as loader_done is latched as pending.
- level_sel never changes while loader_start=1.
- The timeout counter clears on entry to S_LOAD. It must be wide enough to hold TIMEOUT.
- Latency: a request sampled at edge N in S_IDLE with loader_ready=1 gives loader_start=1 after edge N.
- Reset asserted mid-load: loader_start drops immediately (asynchronously) and all state returns to reset values. After reset release, the boot load of level 0 repeats.

Test Plan:
- Reset release with loader_ready=1 and a loader model taking 61 cycles -> start high after the first edge, level_sel=0; after done, cur_level=0, level_valid=1, game_hold=0.
- NUM_LEVELS=2, cur_level=1, next_req pulse -> level_sel=0 (wrap), one load, cur_level=0.
- During a load of level 0, pulse next_req then jump_req with jump_level=1 -> pending=jump. After done: one idle cycle with level_valid=1, then a second load with level_sel=1.
- jump_req with jump_level=2 (NUM_LEVELS=2) together with restart_req -> restart wins, level_sel=cur_level. jump_level=3 alone -> no load, stays in S_IDLE.
- Loader never asserts done -> start drops after 127 cycles, err=1, level_valid=0. next_req is ignored. restart_req causes a retry of the same level; done then clears err and commits.
- Assert reset mid-S_LOAD -> loader_start=0 with no clock edge, cur_level=0, err=0. After release, a boot load of level 0 occurs.
